// File: rtl/hacd_pkg.sv
// Shared HACD types: decompressor scheduler states, completion codes and job payload.
package hacd_pkg;

    localparam int unsigned HACD_PAGE_LINES = 64;
    localparam int unsigned HACD_REQS       = 2;
    localparam int unsigned HACD_SIZE_W     = 14;
    localparam int unsigned HACD_LINES_W    = 7;
    localparam int unsigned HACD_WD_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_CPL   = 3'd4
    } decomp_sched_state_t;

    typedef enum logic [1:0] {
        CPL_OK       = 2'b00,
        CPL_BAD_SIZE = 2'b01,
        CPL_TIMEOUT  = 2'b10,
        CPL_SHORT    = 2'b11
    } decomp_cpl_status_t;

    typedef struct packed {
        logic                   id;
        logic [HACD_SIZE_W-1:0] size;
    } decomp_job_t;

    // A job is decompressible only with a non-empty payload no larger than the limit.
    function automatic logic size_legal(input logic [HACD_SIZE_W-1:0] size,
                                        input int unsigned             max_size);
        return (size != '0) && (size <= HACD_SIZE_W'(max_size));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational pick, registered last-grant pointer.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_id_c,
    output logic       gnt_any_c
);

    logic last_q;
    logic last_d;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        gnt_any_c = |req_i;
        gnt_id_c  = (req_i == 2'b11) ? ~last_q : req_i[1];
        last_d    = last_q;
        if (update_i && gnt_any_c) begin
            last_d = gnt_id_c;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/hacd_decomp_sched.sv
// Schedules restore/migration decompression jobs onto the single page decompressor,
// screening sizes and reporting ok / bad size / timeout / short page per job.
module hacd_decomp_sched
    import hacd_pkg::*;
#(
    parameter int unsigned LINES_PER_PAGE = HACD_PAGE_LINES,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_COMP_SIZE  = 4096
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [HACD_REQS-1:0]                    req_valid,
    input  logic [HACD_REQS-1:0][HACD_SIZE_W-1:0]   req_comp_size,
    output logic [HACD_REQS-1:0]                    req_ready,
    output logic [HACD_REQS-1:0]                    cpl_valid,
    output logic [1:0]                              cpl_status,
    output logic                                    decomp_start,
    output logic [HACD_SIZE_W-1:0]                  decomp_comp_size,
    input  logic                                    decomp_done,
    input  logic                                    dec_wr_req,
    input  logic                                    wrfifo_full,
    output logic                                    busy,
    output logic [HACD_LINES_W-1:0]                 lines_written
);

    decomp_sched_state_t          state_q, state_d;
    decomp_job_t                  job_q, job_d;
    decomp_cpl_status_t           status_q, status_d;
    logic [HACD_LINES_W-1:0]      lines_q, lines_d;
    logic [HACD_WD_W-1:0]         wd_q, wd_d;
    logic [HACD_REQS-1:0]         req_ready_q, req_ready_d;
    logic [HACD_REQS-1:0]         cpl_valid_q, cpl_valid_d;
    logic                         start_q, start_d;
    logic                         busy_q, busy_d;

    logic                         arb_update_c;
    logic                         gnt_id_c;
    logic                         gnt_any_c;
    logic                         beat_c;
    logic [HACD_LINES_W-1:0]      lines_inc_c;
    logic [HACD_WD_W-1:0]         wd_inc_c;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid),
        .update_i  (arb_update_c),
        .gnt_id_c  (gnt_id_c),
        .gnt_any_c (gnt_any_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        status_d     = status_q;
        lines_d      = lines_q;
        wd_d         = wd_q;
        req_ready_d  = '0;
        cpl_valid_d  = '0;
        start_d      = 1'b0;
        arb_update_c = 1'b0;

        beat_c      = dec_wr_req && !wrfifo_full;
        lines_inc_c = (lines_q >= HACD_LINES_W'(LINES_PER_PAGE)) ? lines_q
                                                                 : lines_q + HACD_LINES_W'(1);
        wd_inc_c    = wd_q + HACD_WD_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any_c) begin
                    state_d               = ST_GRANT;
                    arb_update_c          = 1'b1;
                    job_d.id              = gnt_id_c;
                    job_d.size            = req_comp_size[gnt_id_c];
                    req_ready_d[gnt_id_c] = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!size_legal(job_q.size, MAX_COMP_SIZE)) begin
                    state_d                = ST_CPL;
                    status_d               = CPL_BAD_SIZE;
                    cpl_valid_d[job_q.id]  = 1'b1;
                end else begin
                    state_d = ST_START;
                    start_d = 1'b1;
                    lines_d = '0;
                    wd_d    = '0;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
                wd_d    = wd_inc_c;
            end
            ST_RUN: begin
                wd_d = wd_inc_c;
                if (beat_c) begin
                    lines_d = lines_inc_c;
                end
                // Done takes priority over a watchdog expiring in the same cycle.
                if (decomp_done) begin
                    state_d               = ST_CPL;
                    status_d              = (lines_d == HACD_LINES_W'(LINES_PER_PAGE)) ? CPL_OK
                                                                                       : CPL_SHORT;
                    cpl_valid_d[job_q.id] = 1'b1;
                end else if (wd_inc_c == HACD_WD_W'(TIMEOUT_CYCLES)) begin
                    state_d               = ST_CPL;
                    status_d              = CPL_TIMEOUT;
                    cpl_valid_d[job_q.id] = 1'b1;
                end
            end
            ST_CPL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            job_q       <= '0;
            status_q    <= CPL_OK;
            lines_q     <= '0;
            wd_q        <= '0;
            req_ready_q <= '0;
            cpl_valid_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            status_q    <= status_d;
            lines_q     <= lines_d;
            wd_q        <= wd_d;
            req_ready_q <= req_ready_d;
            cpl_valid_q <= cpl_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign cpl_valid        = cpl_valid_q;
    assign cpl_status       = status_q;
    assign decomp_start     = start_q;
    assign decomp_comp_size = job_q.size;
    assign busy             = busy_q;
    assign lines_written    = lines_q;

endmodule

// File: tb/tb_hacd_decomp_sched.sv
// Directed job table plus hand-written reset/stray-done sequences for hacd_decomp_sched.
module tb_hacd_decomp_sched;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0][13:0] req_comp_size = '0;
    logic [1:0]       req_ready;
    logic [1:0]       cpl_valid;
    logic [1:0]       cpl_status;
    logic             decomp_start;
    logic [13:0]      decomp_comp_size;
    logic             decomp_done = 1'b0;
    logic             dec_wr_req = 1'b0;
    logic             wrfifo_full = 1'b0;
    logic             busy;
    logic [6:0]       lines_written;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int cpls   = 0;

    hacd_decomp_sched #(
        .LINES_PER_PAGE (64),
        .TIMEOUT_CYCLES (100),
        .MAX_COMP_SIZE  (4096)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid        (req_valid),
        .req_comp_size    (req_comp_size),
        .req_ready        (req_ready),
        .cpl_valid        (cpl_valid),
        .cpl_status       (cpl_status),
        .decomp_start     (decomp_start),
        .decomp_comp_size (decomp_comp_size),
        .decomp_done      (decomp_done),
        .dec_wr_req       (dec_wr_req),
        .wrfifo_full      (wrfifo_full),
        .busy             (busy),
        .lines_written    (lines_written)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (decomp_start) starts <= starts + 1;
        if (cpl_valid != 2'b00) cpls <= cpls + 1;
    end

    typedef struct {
        logic [1:0]  valid;
        logic [13:0] size0;
        logic [13:0] size1;
        int          beats;
        int          masked;
        bit          done;
        bit          beat_with_done;
        int          exp_id;
        logic [1:0]  exp_status;
        int          exp_lines;
        bit          exp_start;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    n;
        int    total;
        int    starts0;
        string tag;
        tag = $sformatf("v%0d", idx);
        starts0 = starts;
        req_valid = v.valid;
        req_comp_size[0] = v.size0;
        req_comp_size[1] = v.size1;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == 2'b00 && n < 10);
        req_valid = 2'b00;
        check({tag, "_ready_lat"}, n, 1);
        if (req_ready == 2'b00) return;
        check({tag, "_ready_id"}, int'(req_ready), 1 << v.exp_id);
        check({tag, "_busy_grant"}, int'(busy), 1);
        check({tag, "_size"}, int'(decomp_comp_size), int'(v.exp_id == 0 ? v.size0 : v.size1));
        tick();
        if (!v.exp_start) begin
            check({tag, "_badsz_cpl"}, int'(cpl_valid), 1 << v.exp_id);
            check({tag, "_badsz_status"}, int'(cpl_status), int'(v.exp_status));
            check({tag, "_badsz_nostart"}, int'(decomp_start), 0);
        end else begin
            check({tag, "_start"}, int'(decomp_start), 1);
            if (v.done) begin
                tick();
                total = v.beats + v.masked;
                for (int i = 0; i < total; i++) begin
                    dec_wr_req  = 1'b1;
                    wrfifo_full = (i < v.masked);
                    decomp_done = v.beat_with_done && (i == total - 1);
                    tick();
                end
                dec_wr_req  = 1'b0;
                wrfifo_full = 1'b0;
                if (!v.beat_with_done) begin
                    decomp_done = 1'b1;
                    tick();
                end
                decomp_done = 1'b0;
            end else begin
                n = 0;
                do begin
                    tick();
                    n++;
                end while (cpl_valid == 2'b00 && n < 200);
                check({tag, "_timeout_lat"}, n, 100);
            end
            check({tag, "_cpl"}, int'(cpl_valid), 1 << v.exp_id);
            check({tag, "_status"}, int'(cpl_status), int'(v.exp_status));
            check({tag, "_lines"}, int'(lines_written), v.exp_lines);
        end
        tick();
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_cpl"}, int'(cpl_valid), 0);
        check({tag, "_starts"}, starts - starts0, v.exp_start ? 1 : 0);
    endtask

    initial begin
        //          valid  size0  size1 beats msk done bwd id status lines start
        vecs[0] = '{2'b11, 14'd1200, 14'd2000, 64, 0, 1'b1, 1'b0, 0, 2'b00, 64, 1'b1};
        vecs[1] = '{2'b11, 14'd1200, 14'd2000, 64, 0, 1'b1, 1'b1, 1, 2'b00, 64, 1'b1};
        vecs[2] = '{2'b11, 14'd4096, 14'd300,  40, 5, 1'b1, 1'b0, 0, 2'b11, 40, 1'b1};
        vecs[3] = '{2'b01, 14'd0,    14'd0,     0, 0, 1'b0, 1'b0, 0, 2'b01, -1, 1'b0};
        vecs[4] = '{2'b10, 14'd0,    14'd5000,  0, 0, 1'b0, 1'b0, 1, 2'b01, -1, 1'b0};
        vecs[5] = '{2'b10, 14'd0,    14'd1,    70, 0, 1'b1, 1'b0, 1, 2'b00, 64, 1'b1};
        vecs[6] = '{2'b01, 14'd3000, 14'd0,     0, 0, 1'b0, 1'b0, 0, 2'b10,  0, 1'b1};

        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_ready", int'(req_ready), 0);
        check("rst_cpl", int'(cpl_valid), 0);
        check("rst_status", int'(cpl_status), 0);
        check("rst_start", int'(decomp_start), 0);
        check("rst_size", int'(decomp_comp_size), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_lines", int'(lines_written), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Stray done after the timeout completion must be ignored.
        begin
            int cpls0;
            cpls0 = cpls;
            decomp_done = 1'b1;
            tick();
            decomp_done = 1'b0;
            check("stray_busy", int'(busy), 0);
            check("stray_cpl", int'(cpl_valid), 0);
            repeat (3) tick();
            check("stray_cpl_cnt", cpls - cpls0, 0);
        end

        // Reset while a job is running: no completion, everything back to reset values.
        begin
            int cpls0;
            int n;
            req_valid = 2'b01;
            req_comp_size[0] = 14'd500;
            n = 0;
            do begin
                tick();
                n++;
            end while (req_ready == 2'b00 && n < 10);
            req_valid = 2'b00;
            check("mid_ready", int'(req_ready), 1);
            tick();
            check("mid_start", int'(decomp_start), 1);
            tick();
            for (int i = 0; i < 10; i++) begin
                dec_wr_req = 1'b1;
                tick();
            end
            dec_wr_req = 1'b0;
            check("mid_lines", int'(lines_written), 10);
            cpls0 = cpls;
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            check("mid_rst_ready", int'(req_ready), 0);
            check("mid_rst_cpl", int'(cpl_valid), 0);
            check("mid_rst_status", int'(cpl_status), 0);
            check("mid_rst_start", int'(decomp_start), 0);
            check("mid_rst_size", int'(decomp_comp_size), 0);
            check("mid_rst_busy", int'(busy), 0);
            check("mid_rst_lines", int'(lines_written), 0);
            decomp_done = 1'b1;
            tick();
            decomp_done = 1'b0;
            repeat (3) tick();
            check("mid_rst_no_cpl", cpls - cpls0, 0);
        end

        // Fresh request after reset: pointer reset makes requester 0 win contention.
        begin
            vec_t v;
            v = '{2'b11, 14'd700, 14'd800, 64, 0, 1'b1, 1'b0, 0, 2'b00, 64, 1'b1};
            run_vec(7, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
